// File: rtl/bcd_event_encoder.sv
// bcd_event_encoder
// Watches N level-sensitive request lines, latches every rising edge as a
// pending event and hands the events out one at a time, as binary indices,
// through a valid/ready port. Priority is fixed by MSB_FIRST. A rising edge on
// a line that is already pending (and not being served that cycle) is
// reported with a one-cycle drop pulse.
module bcd_event_encoder #(
  parameter int N         = 10,
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] v,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         drop
);

  // Output slot: EMPTY has nothing to offer, FULL presents y downstream.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e          state_q, state_d;
  logic [N-1:0]   v_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   y_q, y_d;
  logic           drop_q, drop_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   pend_rev;
  logic [N-1:0]   rev_iso;
  logic [N-1:0]   lsb_iso;
  logic [N-1:0]   pick_hot;
  logic [W-1:0]   pick_idx;
  logic [N-1:0]   pick_mask;
  logic           load;
  logic           take;

  // Rising-edge detect, gated by the capture enable.
  always_comb begin
    rise = v & ~v_q & {N{en}};
  end

  // Isolate the winning pending bit (one-hot) and encode it as a binary index.
  always_comb begin
    pend_rev = '0;
    pick_hot = '0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      pend_rev[i] = pend_q[N-1-i];
    end
    // x & (~x + 1) keeps only the lowest set bit; reversing first turns that
    // into "highest set bit" for the MSB-first order.
    lsb_iso = pend_q & (~pend_q + N'(1));
    rev_iso = pend_rev & (~pend_rev + N'(1));
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        pick_hot[i] = rev_iso[N-1-i];
      end
    end else begin
      pick_hot = lsb_iso;
    end
    for (int i = 0; i < N; i++) begin
      pick_idx = pick_idx | ({W{pick_hot[i]}} & W'(i));
    end
  end

  // Next-state: slot load/hold, pending-mask update and drop detection.
  always_comb begin
    case (state_q)
      SLOT_EMPTY: load = 1'b1;
      SLOT_FULL:  load = ready;
      default:    load = 1'b1;
    endcase
    // Only the registered pending mask is eligible; this cycle's rises wait.
    take      = load & (|pend_q);
    pick_mask = take ? pick_hot : '0;
    // A rise on the bit being served re-arms it as a fresh event (no drop).
    pend_d    = (pend_q & ~pick_mask) | rise;
    drop_d    = |(rise & pend_q & ~pick_mask);
    y_d       = y_q;
    state_d   = state_q;
    if (take) begin
      y_d     = pick_idx;
      state_d = SLOT_FULL;
    end else if (load) begin
      state_d = SLOT_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      v_q     <= '0;
      pend_q  <= '0;
      y_q     <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v;
      pend_q  <= pend_d;
      y_q     <= y_d;
      drop_q  <= drop_d;
    end
  end

  assign y     = y_q;
  assign valid = (state_q == SLOT_FULL);
  assign pend  = pend_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_bcd_event_encoder.sv
// Self-checking bench for bcd_event_encoder: two instances (LSB-first and
// MSB-first) share one stimulus stream and are compared every cycle against
// a behavioural event-queue model, plus directed spot checks.
module tb_bcd_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n, en, ready;
  logic [9:0] v;
  logic [3:0] y0, y1;
  logic       valid0, valid1, drop0, drop1;
  logic [9:0] pend0, pend1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 = lowest-first, 1 = highest-first.
  logic [9:0] m_vq   [2];
  logic [9:0] m_pend [2];
  logic [3:0] m_y    [2];
  logic       m_valid[2];
  logic       m_drop [2];

  bcd_event_encoder #(.N(10), .W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .v(v), .y(y0), .valid(valid0),
    .ready(ready), .pend(pend0), .drop(drop0));

  bcd_event_encoder #(.N(10), .W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .v(v), .y(y1), .valid(valid1),
    .ready(ready), .pend(pend1), .drop(drop1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_vq[m] = '0; m_pend[m] = '0; m_y[m] = '0; m_valid[m] = 1'b0; m_drop[m] = 1'b0;
      end else begin
        int  pick = -1;
        bit  r;
        if (!m_valid[m] || ready) begin
          for (int k = 0; k < 10; k++) begin
            int i = (m == 1) ? 9 - k : k;
            if (pick < 0 && m_pend[m][i]) pick = i;
          end
          if (pick >= 0) begin
            m_y[m] = 4'(pick);
            m_valid[m] = 1'b1;
          end else begin
            m_valid[m] = 1'b0;
          end
        end
        m_drop[m] = 1'b0;
        for (int i = 0; i < 10; i++) begin
          r = v[i] && !m_vq[m][i] && en;
          if (r && m_pend[m][i] && i != pick) m_drop[m] = 1'b1;
          m_pend[m][i] = (m_pend[m][i] && i != pick) || r;
        end
        m_vq[m] = v;
      end
    end
  endtask

  task automatic compare_all();
    check("lsb_y",     {12'h000, y0},          {12'h000, m_y[0]});
    check("lsb_valid", {15'h0000, valid0},     {15'h0000, m_valid[0]});
    check("lsb_pend",  {6'h00, pend0},         {6'h00, m_pend[0]});
    check("lsb_drop",  {15'h0000, drop0},      {15'h0000, m_drop[0]});
    check("msb_y",     {12'h000, y1},          {12'h000, m_y[1]});
    check("msb_valid", {15'h0000, valid1},     {15'h0000, m_valid[1]});
    check("msb_pend",  {6'h00, pend1},         {6'h00, m_pend[1]});
    check("msb_drop",  {15'h0000, drop1},      {15'h0000, m_drop[1]});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_vq[m] = '0; m_pend[m] = '0; m_y[m] = '0; m_valid[m] = 1'b0; m_drop[m] = 1'b0;
    end
    rst_n = 1'b0; en = 1'b1; ready = 1'b0; v = 10'h3FF;

    // Reset with all lines high, then release: every line counts as one edge.
    cycle(); cycle();
    check("rst_valid", {15'h0000, valid0}, 16'h0000);
    check("rst_pend",  {6'h00, pend0},     16'h0000);
    rst_n = 1'b1; ready = 1'b1;
    cycle();
    check("rel_pend", {6'h00, pend0}, 16'h03FF);
    check("rel_valid", {15'h0000, valid0}, 16'h0000);
    cycle();
    check("first_valid", {15'h0000, valid0}, 16'h0001);
    check("first_y",     {12'h000, y0},      16'h0000);
    check("first_y_msb", {12'h000, y1},      16'h0009);
    for (int k = 0; k < 10; k++) cycle();
    check("drained_valid", {15'h0000, valid0}, 16'h0000);
    v = 10'h000;
    cycle();

    // Single key with stalled consumer.
    ready = 1'b0; v = 10'h080; cycle();
    v = 10'h000;
    for (int k = 0; k < 20; k++) cycle();
    check("stall_y",     {12'h000, y0},      16'h0007);
    check("stall_valid", {15'h0000, valid0}, 16'h0001);
    ready = 1'b1; cycle();
    check("stall_release", {15'h0000, valid0}, 16'h0000);
    ready = 1'b0; cycle();

    // Simultaneous rises on 2, 5, 9.
    ready = 1'b1; v = 10'h224; cycle();
    v = 10'h000; cycle();
    check("prio1_lsb", {12'h000, y0}, 16'h0002);
    check("prio1_msb", {12'h000, y1}, 16'h0009);
    cycle();
    check("prio2_lsb", {12'h000, y0}, 16'h0005);
    check("prio2_msb", {12'h000, y1}, 16'h0005);
    cycle();
    check("prio3_lsb", {12'h000, y0}, 16'h0009);
    check("prio3_msb", {12'h000, y1}, 16'h0002);
    cycle();

    // Drop: slot holds 3, key 4 rises twice while pending.
    ready = 1'b0; v = 10'h008; cycle();
    v = 10'h000; cycle();
    v = 10'h010; cycle();
    v = 10'h000; cycle();
    v = 10'h010; cycle();
    check("drop_pulse", {15'h0000, drop0}, 16'h0001);
    v = 10'h000; cycle();
    check("drop_clear", {15'h0000, drop0}, 16'h0000);

    // Same-cycle pick and rise on key 4.
    ready = 1'b1; v = 10'h010; cycle();
    check("same_y",    {12'h000, y0},      16'h0004);
    check("same_pend", {6'h00, pend0},     16'h0010);
    check("same_drop", {15'h0000, drop0},  16'h0000);
    v = 10'h000; cycle();
    check("same_y2",   {12'h000, y0},      16'h0004);
    cycle();

    // Enable gating: edge while disabled is lost for good.
    en = 1'b0; v = 10'h002; cycle();
    en = 1'b1; cycle(); cycle();
    check("en_pend",  {6'h00, pend0},     16'h0000);
    check("en_valid", {15'h0000, valid0}, 16'h0000);
    v = 10'h000; cycle();

    // Mid-operation reset with a live event and ready high.
    ready = 1'b0; v = 10'h040; cycle();
    v = 10'h000; cycle();
    check("mid_y", {12'h000, y0}, 16'h0006);
    ready = 1'b1; rst_n = 1'b0; cycle();
    check("mid_valid", {15'h0000, valid0}, 16'h0000);
    check("mid_pend",  {6'h00, pend0},     16'h0000);
    rst_n = 1'b1; ready = 1'b0; cycle();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      v     = v ^ (10'($urandom) & 10'($urandom) & 10'($urandom));
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_event_encoder.md
Name: bcd_event_encoder

Overview:
- Parametrised, registered successor to the combinational decimal-to-BCD encoder.
- Watches N request lines (default 10, one per decimal key). Captures each rising edge as a pending event. Drains pending events one at a time as binary indices through a valid/ready output port.
- Sits between debounced key/switch inputs and the downstream digit consumer (display driver, accumulator).
- Priority order is fixed by parameter. Lost events are flagged.

Parameters:
- N, 10, number of request lines; legal range 1..64.
- W, 4, output index width; must be >= max(1, clog2(N)); upper bits zero-filled.
- MSB_FIRST, 0, priority order: 0 = lowest index served first, 1 = highest index served first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  capture enable; 0 ignores new edges, draining continues.
- v  input  N  request lines, synchronous to clk, level-sensitive.
- y  output  W  binary index of the event presented; stable while valid=1 and ready=0.
- valid  output  1  y holds a live event.
- ready  input  1  consumer accepts; transfer = valid & ready at a clock edge.
- pend  output  N  pending-event mask (registered), for status/debug.
- drop  output  1  one-cycle pulse: an edge arrived on a line already pending.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all of the following clear to 0: v_q (previous-sample register), pend, y, valid, drop. Reset has priority over all other activity. An in-flight event is discarded, even if ready=1 that cycle.
- Edge detect:
  - rise = v & ~v_q & {N{en}}.
  - v_q <= v every cycle, regardless of en.
  - A line held high through reset release counts as one edge on the first post-reset cycle.
- Slot states:
  - EMPTY (valid=0) and FULL (valid=1).
  - Load condition: state is EMPTY, or FULL with ready=1.
- On a load cycle, with pend non-zero:
  - Select index i = lowest set bit of pend (MSB_FIRST=0) or highest set bit (MSB_FIRST=1).
  - Update: y<=i, valid<=1, pend[i] cleared.
  - Selection uses the registered pend only; this cycle's rises are not eligible.
- On a load cycle with pend zero: valid<=0 and y holds its old value.
- FULL with ready=0: y, valid and the selected slot hold. pend still accumulates new rises.
- ready while EMPTY is ignored.
- Next pend = (pend & ~pick) | rise, per bit:
  - Rise on the bit being picked in the same cycle: the bit stays set, counted as a new event, no drop.
  - Rise on a bit already pending and not picked: the bit stays set, drop<=1 for the next cycle.
  - Otherwise drop<=0.
- Latency: v[i] sampled high at edge k (v_q[i]=0, en=1) -> pend[i]=1 after edge k -> valid=1, y=i after edge k+1 (slot free).
- Throughput: one event per clock when ready is held high. Back-to-back transfers have no bubble while pend is non-zero.
- Level semantics: a line held high yields exactly one event. A line must return low for at least one sampled cycle before it can re-trigger.
- Multiple simultaneous rises are all captured and served in priority order over successive transfers.
- en=0: v_q keeps tracking v. An edge occurring while en=0 is lost permanently; no retroactive capture when en returns to 1.
- Width: for i < N, y = i zero-extended to W. No index >= N is ever produced.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with v=10'h3FF, then release -> cycle 1: pend=10'h3FF. Cycle 2: valid=1, y=0. With ready=1 held, y=0..9 on consecutive cycles, then valid=0, drop never asserted.
- Single key, stalled consumer: v[7] pulse 1 cycle, ready=0 -> valid=1, y=7 held for 20 cycles; pend=0. Assert ready for 1 cycle -> valid=0 next cycle.
- Priority order: v[2], v[5], v[9] rise together, ready=1. MSB_FIRST=0 -> y sequence 2, 5, 9. Repeat with MSB_FIRST=1, N=10 -> 9, 5, 2.
- Drop: ready=0, slot holds y=3. v[4] pulses twice (low gap between) while pend[4]=1 -> drop=1 for exactly one cycle after the second rise; a single event y=4 is later delivered.
- Same-cycle pick and rise: pend={4}, slot empty, v[4] rises that cycle -> y=4 delivered, pend[4] remains 1, drop=0; a second y=4 follows.
- Enable and mid-operation reset: en=0 while v[1] rises -> no event, pend=0. en=1 with v[1] still high -> no event. Then, with valid=1, y=6 and ready=1, rst_n=0 -> valid=0, pend=0 next cycle, no transfer counted.
